// File: rtl/axis_sample_feeder.sv
// axis_sample_feeder
//   AXI-Stream source that reads cfg_len consecutive samples from a sample BRAM
//   (byte address cfg_base, stride 4) and streams them out with ss_tlast on the
//   final beat. A small prefetch FIFO hides the 1-cycle BRAM read latency so a
//   beat per cycle is sustained while ss_tready is held high.
//
// Ports
//   axis_clk / axis_rst_n     : clock, asynchronous active-low reset
//   cfg_start/cfg_base/cfg_len: start pulse and frame config (captured in IDLE)
//   busy / done               : frame in progress / one-cycle completion pulse
//   src_EN / src_A / src_Do   : BRAM read port (data valid 1 cycle after src_EN)
//   ss_tvalid/tdata/tlast/tready : AXI-Stream master
//   stall_cnt                 : only with FEEDER_STALL_CNT_EN defined; counts
//                               ss_tvalid && !ss_tready cycles during a frame
//
// Build option: define FEEDER_STALL_CNT_EN to add the stall_cnt port.
module axis_sample_feeder #(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pDATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   cfg_start,
   input  logic [pADDR_WIDTH-1:0] cfg_base,
   input  logic [pADDR_WIDTH-1:0] cfg_len,
   output logic                   busy,
   output logic                   done,
   output logic                   src_EN,
   output logic [pADDR_WIDTH-1:0] src_A,
   input  logic [pDATA_WIDTH-1:0] src_Do,
   output logic                   ss_tvalid,
   output logic [pDATA_WIDTH-1:0] ss_tdata,
   output logic                   ss_tlast,
   input  logic                   ss_tready
`ifdef FEEDER_STALL_CNT_EN
   ,
   output logic [31:0]            stall_cnt
`endif
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0]        DepthC = CntW'(FIFO_DEPTH);
   localparam logic [pADDR_WIDTH-1:0] OneA   = pADDR_WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e                 state_q, state_d;
   logic [pADDR_WIDTH-1:0] base_q, len_q, rd_cnt_q, tx_cnt_q;
   logic                   inflight_q;
   logic                   busy_q, done_q;
   logic [pDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]        count_q, fill;
   logic                   accept, issue, push, pop, last_beat;

   always_comb begin
      accept    = (state_q == StIdle) && cfg_start;
      // In-flight read already owns a FIFO slot, so overflow is impossible.
      fill      = count_q + CntW'(inflight_q);
      issue     = (state_q == StRun) && (rd_cnt_q < len_q) && (fill < DepthC);
      push      = inflight_q;
      ss_tvalid = (count_q != '0);
      pop       = ss_tvalid && ss_tready;
      last_beat = (tx_cnt_q == len_q - OneA);
      ss_tlast  = ss_tvalid && last_beat;
      ss_tdata  = mem_q[rd_ptr_q];
      src_EN    = issue;
      // Address wraps modulo 2^pADDR_WIDTH.
      src_A     = issue ? (base_q + (rd_cnt_q << 2)) : '0;
      busy      = busy_q;
      done      = done_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cfg_start) state_d = (cfg_len == '0) ? StDone : StRun;
         StRun:   if (issue && (rd_cnt_q + OneA == len_q)) state_d = StDrain;
         StDrain: if (pop && last_beat) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q    <= StIdle;
         base_q     <= '0;
         len_q      <= '0;
         rd_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         inflight_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= (state_d == StRun) || (state_d == StDrain);
         done_q     <= (state_d == StDone);
         inflight_q <= issue;
         if (accept) begin
            base_q   <= cfg_base;
            len_q    <= cfg_len;
            rd_cnt_q <= '0;
            tx_cnt_q <= '0;
         end else begin
            if (issue) rd_cnt_q <= rd_cnt_q + OneA;
            if (pop)   tx_cnt_q <= tx_cnt_q + OneA;
         end
      end
   end

   // Prefetch FIFO: BRAM data lands one edge after the read was issued.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= src_Do;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef FEEDER_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         stall_q <= '0;
      end else if (accept) begin
         stall_q <= '0;
      end else if (((state_q == StRun) || (state_q == StDrain)) && ss_tvalid && !ss_tready
                   && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule
